pipeline_hazard_ctrl: RTL and testbench

Stall and flush controller for the 5-stage RISC-V pipeline. It drives the enable inputs of the PC, IF/ID and ID/EX registers, and the flush/bubble controls that zero the control bits those registers capture. It detects load-use hazards between the instruction in ID/EX and the instruction being decoded, handles taken branch/JALR redirects resolved in EX, and freezes the pipeline during multi-cycle data-memory accesses. It also keeps a saturating stall-cycle counter for performance statistics.

---
 rtl/pipeline_hazard_ctrl_if.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 83 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline-register control outputs of the
// stall/flush controller, grouped as one bus.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_write_register;
  logic             redirect;
  logic             mem_busy;
  logic             stat_clear;
  logic             pc_enable;
  logic             if_id_enable;
  logic             id_ex_enable;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read,
           ex_write_register, redirect, mem_busy, stat_clear,
    input  pc_enable, if_id_enable, id_ex_enable, if_id_flush, id_ex_bubble,
           stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read,
           ex_write_register, redirect, mem_busy, stat_clear,
    output pc_enable, if_id_enable, id_ex_enable, if_id_flush, id_ex_bubble,
           stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, redirect
// flushes, memory freezes and a saturating stall-cycle statistic.
module pipeline_hazard_ctrl #(
  parameter int unsigned LU_CYCLES    = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} state_e;

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             pc_en, if_id_en, id_ex_en, flush, bubble;

  assign lu = bus.ex_mem_read && (bus.ex_write_register != 5'd0) &&
              ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_write_register)) ||
               (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_write_register)));

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    pc_en    = 1'b0;
    if_id_en = 1'b0;
    id_ex_en = 1'b0;
    flush    = 1'b0;
    bubble   = 1'b0;
    if (bus.mem_busy) begin
      // LU_STALL/FLUSH keep state and rem so the sequence resumes on release
      if (state_q == RUN || state_q == MEM_WAIT) state_d = MEM_WAIT;
    end else if (bus.redirect) begin
      {pc_en, if_id_en, id_ex_en, flush, bubble} = 5'b11111;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      rem_d   = 3'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      {pc_en, if_id_en, id_ex_en, flush, bubble} = 5'b11111;
      rem_d   = rem_q - 3'd1;
      state_d = (rem_q == 3'd1) ? RUN : FLUSH;
    end else if (state_q == LU_STALL) begin
      {pc_en, if_id_en, id_ex_en, flush, bubble} = 5'b00101;
      rem_d   = rem_q - 3'd1;
      state_d = (rem_q == 3'd1) ? RUN : LU_STALL;
    end else if (lu) begin
      {pc_en, if_id_en, id_ex_en, flush, bubble} = 5'b00101;
      state_d = (LU_CYCLES > 1) ? LU_STALL : RUN;
      rem_d   = 3'(LU_CYCLES - 1);
    end else begin
      {pc_en, if_id_en, id_ex_en, flush, bubble} = 5'b11100;
      state_d = RUN;
      rem_d   = '0;
    end
    if (!reset) {pc_en, if_id_en, id_ex_en, flush, bubble} = 5'b00000;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.stat_clear) cnt_d = '0;
    else if (!pc_en && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_enable    = pc_en;
  assign bus.if_id_enable = if_id_en;
  assign bus.id_ex_enable = id_ex_en;
  assign bus.if_id_flush  = flush;
  assign bus.id_ex_bubble = bubble;
  assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations (LU=1/CNT_W=16 and
// LU=2/CNT_W=4) driven in parallel and checked against a counting model.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b1;
  logic       reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_wr = '0;
  logic       u1 = 0, u2 = 0, mem_read = 0, redirect = 0, mem_busy = 0, stat_clear = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) ifa ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  ifb ();

  assign {ifa.id_rs1, ifa.id_rs2, ifa.ex_write_register} = {id_rs1, id_rs2, ex_wr};
  assign {ifb.id_rs1, ifb.id_rs2, ifb.ex_write_register} = {id_rs1, id_rs2, ex_wr};
  assign {ifa.id_uses_rs1, ifa.id_uses_rs2, ifa.ex_mem_read} = {u1, u2, mem_read};
  assign {ifb.id_uses_rs1, ifb.id_uses_rs2, ifb.ex_mem_read} = {u1, u2, mem_read};
  assign {ifa.redirect, ifa.mem_busy, ifa.stat_clear} = {redirect, mem_busy, stat_clear};
  assign {ifb.redirect, ifb.mem_busy, ifb.stat_clear} = {redirect, mem_busy, stat_clear};

  pipeline_hazard_ctrl #(.LU_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  pipeline_hazard_ctrl #(.LU_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  // Model: owed flush / load-use cycles and a stall tally per configuration.
  int lu_len [2] = '{1, 2};
  int cnt_max[2] = '{65535, 15};
  int fl_owed[2], lu_owed[2], cnt[2];
  localparam int FL_LEN = 2;

  function automatic logic hazard();
    return mem_read && ex_wr != 0 && ((u1 && id_rs1 == ex_wr) || (u2 && id_rs2 == ex_wr));
  endfunction

  // {pc_enable, if_id_enable, id_ex_enable, if_id_flush, id_ex_bubble}
  function automatic logic [4:0] expect_ctrl(int k);
    if (!reset || mem_busy)                 return 5'b00000;
    if (redirect || fl_owed[k] > 0)         return 5'b11111;
    if (lu_owed[k] > 0 || hazard())         return 5'b00101;
    return 5'b11100;
  endfunction

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin fl_owed[k] = 0; lu_owed[k] = 0; cnt[k] = 0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [4:0] o;
        o = expect_ctrl(k);
        if (stat_clear) cnt[k] = 0;
        else if (!o[4] && cnt[k] < cnt_max[k]) cnt[k]++;
        if (!mem_busy) begin
          if (redirect) begin fl_owed[k] = FL_LEN - 1; lu_owed[k] = 0; end
          else if (fl_owed[k] > 0) fl_owed[k]--;
          else if (lu_owed[k] > 0) lu_owed[k]--;
          else if (hazard()) lu_owed[k] = lu_len[k] - 1;
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare, mid-cycle between the negedge update points.
  always @(posedge clk) begin
    chk("a_ctrl", {ifa.pc_enable, ifa.if_id_enable, ifa.id_ex_enable, ifa.if_id_flush,
                   ifa.id_ex_bubble}, expect_ctrl(0));
    chk("b_ctrl", {ifb.pc_enable, ifb.if_id_enable, ifb.id_ex_enable, ifb.if_id_flush,
                   ifb.id_ex_bubble}, expect_ctrl(1));
    chk("a_stall_cycles", int'(ifa.stall_cycles), cnt[0]);
    chk("b_stall_cycles", int'(ifb.stall_cycles), cnt[1]);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_wr} = '0;
    {u1, u2, mem_read, redirect, mem_busy, stat_clear} = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_a_pc", ifa.pc_enable, 0);
    chk("rst_a_idex", ifa.id_ex_enable, 0);
    chk("rst_a_cnt", int'(ifa.stall_cycles), 0);
    do_reset();
    #1 chk("idle_a_pc", ifa.pc_enable, 1);
    step();

    // load-use on rs2
    mem_read = 1; ex_wr = 5; id_rs2 = 5; u2 = 1;
    #1 chk("lu_a_pc", ifa.pc_enable, 0);
    chk("lu_a_ifid", ifa.if_id_enable, 0);
    chk("lu_a_bubble", ifa.id_ex_bubble, 1);
    chk("lu_a_idex", ifa.id_ex_enable, 1);
    step(); idle();
    #1 chk("lu_after_a_pc", ifa.pc_enable, 1);
    chk("lu_after_a_cnt", int'(ifa.stall_cycles), 1);
    chk("lu_after_b_pc", ifb.pc_enable, 0);
    step(); step();

    // x0 destination and unused operand never stall
    do_reset();
    mem_read = 1; ex_wr = 0; id_rs1 = 0; u1 = 1;
    #1 chk("x0_a_pc", ifa.pc_enable, 1);
    step();
    ex_wr = 7; id_rs1 = 7; u1 = 0;
    #1 chk("unused_a_pc", ifa.pc_enable, 1);
    step(); idle();
    #1 chk("nostall_a_cnt", int'(ifa.stall_cycles), 0);

    // redirect: two flush cycles, then redirect beats load-use
    redirect = 1;
    #1 chk("rd1_a_flush", ifa.if_id_flush, 1);
    chk("rd1_a_pc", ifa.pc_enable, 1);
    step(); redirect = 0;
    #1 chk("rd2_a_flush", ifa.if_id_flush, 1);
    chk("rd2_a_bubble", ifa.id_ex_bubble, 1);
    step();
    #1 chk("rd3_a_flush", ifa.if_id_flush, 0);
    redirect = 1; mem_read = 1; ex_wr = 3; id_rs1 = 3; u1 = 1;
    #1 chk("rdlu_a_pc", ifa.pc_enable, 1);
    chk("rdlu_a_flush", ifa.if_id_flush, 1);
    step(); idle(); step(); step();

    // memory freeze in the middle of a 2-cycle load-use stall
    do_reset();
    mem_read = 1; ex_wr = 9; id_rs1 = 9; u1 = 1;
    #1 chk("mf_b_pc", ifb.pc_enable, 0);
    step(); idle(); mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mf_frozen_b_bubble", ifb.id_ex_bubble, 0);
      step();
    end
    mem_busy = 0;
    #1 chk("mf_rem_b_pc", ifb.pc_enable, 0);
    chk("mf_rem_b_bubble", ifb.id_ex_bubble, 1);
    step();
    #1 chk("mf_done_b_pc", ifb.pc_enable, 1);
    chk("mf_done_b_cnt", int'(ifb.stall_cycles), 5);
    chk("mf_done_a_cnt", int'(ifa.stall_cycles), 4);

    // saturation and clear
    do_reset();
    mem_busy = 1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_b_cnt", int'(ifb.stall_cycles), 15);
    chk("sat_a_cnt", int'(ifa.stall_cycles), 20);
    stat_clear = 1;
    step(); stat_clear = 0;
    chk("clr_b_cnt", int'(ifb.stall_cycles), 0);
    mem_busy = 0;
    step();

    // reset during the second flush cycle
    do_reset();
    redirect = 1;
    step(); redirect = 0;
    reset = 0;
    #1 chk("rstfl_a_pc", ifa.pc_enable, 0);
    chk("rstfl_a_flush", ifa.if_id_flush, 0);
    chk("rstfl_a_cnt", int'(ifa.stall_cycles), 0);
    step(); reset = 1;
    #1 chk("post_a_pc", ifa.pc_enable, 1);
    chk("post_a_flush", ifa.if_id_flush, 0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
